serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder/subtractor.
// Adds DIGIT bits per clock; result, carry and overflow appear with a done pulse.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  // r_acc starts as operand A; result slices shift in at the top
  // while A slices are consumed from the bottom.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_load;
  logic             w_last;
  logic [DIGIT:0]   w_slice;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_msb_cin;

  assign w_load = (r_state != S_RUN) && start;
  assign w_last = (r_cnt == CW'(N - 1));

  assign w_slice = {1'b0, r_acc[DIGIT-1:0]}
                 + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};

  // Carry into the top bit recovered from that bit's operands and sum.
  assign w_msb_cin = r_acc[DIGIT-1] ^ r_b[DIGIT-1] ^ w_slice[DIGIT-1];

  generate
    if (DIGIT == WIDTH) begin : g_one
      assign w_acc_next = w_slice[DIGIT-1:0];
    end else begin : g_many
      assign w_acc_next = {w_slice[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, per-digit add and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_acc   <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= cin ^ sub;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_next;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_slice[DIGIT];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_slice[DIGIT];
        r_ovf  <= w_msb_cin ^ w_slice[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, random ops,
// control corner cases and an exhaustive 4-bit sweep for several digit sizes.
module tb_serial_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        s_start;
  logic        s_sub;
  logic        s_cin;
  logic [3:0]  s_a;
  logic [3:0]  s_b;
  logic [2:0]  s_busy;
  logic [2:0]  s_done;
  logic [2:0]  s_cout;
  logic [2:0]  s_ovf;
  logic [3:0]  s_sum [3];

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  for (genvar g = 0; g < 3; g++) begin : g_small
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    serial_adder #(.WIDTH(4), .DIGIT(D)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .sub(s_sub),
      .a(s_a), .b(s_b), .cin(s_cin),
      .busy(s_busy[g]), .done(s_done[g]), .sum(s_sum[g]),
      .cout(s_cout[g]), .ovf(s_ovf[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference arithmetic: unsigned sum for result/carry, signed
  // range check of the true result for overflow.
  function automatic void model(input int w, input longint av,
                                input longint bv, input bit sb,
                                input bit cb, output longint s,
                                output bit co, output bit ov);
    longint one  = 1;
    longint mask = (one << w) - 1;
    longint bp   = sb ? (~bv & mask) : bv;
    longint raw  = av + bp + longint'(cb ^ sb);
    longint half = one << (w - 1);
    longint sa   = (av >= half) ? av - (one << w) : av;
    longint sbv  = (bv >= half) ? bv - (one << w) : bv;
    longint t    = sb ? sa - sbv - longint'(cb) : sa + sbv + longint'(cb);
    s  = raw & mask;
    co = ((raw >> w) & 1) != 0;
    ov = (t >= half) || (t < -half);
  endfunction

  // Wait for done; lat is the edge count since the sampling edge (0 on timeout).
  task automatic wait_done(input int k0, output int lat);
    lat = 0;
    for (int k = k0 + 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic icin,
                        output int lat, output int bc);
    @(negedge clk);
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    sub = 1'($urandom); cin = 1'($urandom);
    bc  = busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt[8];

  initial begin
    int     lat;
    int     bc;
    int     seen;
    longint ms;
    bit     mco;
    bit     mov;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic        rc;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1};
    vt[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vt[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0;
    a = '0; b = '0;
    s_start = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_res", {cout, ovf, sum}, 32'd0);
    rst = 1'b0;

    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin, lat, bc);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vt[i].s));
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vt[i].co));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].ov));
      if (i == 0) check("busy_cycles", 32'(bc), 32'd4);
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse", i), 32'(done), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom);  rc = 1'($urandom);
      if (i < 4) rb = ~ra;
      model(16, longint'(ra), longint'(rb), rs, rc, ms, mco, mov);
      run_op(ra, rb, rs, rc, lat, bc);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd4);
      check($sformatf("rnd%0d_res", i), {cout, ovf, sum},
            {14'd0, mco, mov, 16'(ms)});
    end

    // Start while busy must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h1111; sub = 1'b1; cin = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, lat);
    check("ign_lat", 32'(lat), 32'd4);
    check("ign_res", {cout, ovf, sum}, 32'h5555);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    check("ign_no_second", 32'(seen), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_res", {cout, ovf, sum}, 32'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    check("midrst_res_hold", {cout, ovf, sum}, 32'd0);

    // Back-to-back: start issued in the DONE cycle.
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, lat);
    check("b2b_lat1", 32'(lat), 32'd4);
    check("b2b_res1", {cout, ovf, sum}, 32'h0300);
    a = 16'h7FFF; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_hold", {cout, ovf, sum}, 32'h0300);
    wait_done(0, lat);
    check("b2b_lat2", 32'(lat), 32'd4);
    check("b2b_res2", {cout, ovf, sum}, 32'h1_8000);

    // Exhaustive 4-bit sweep for DIGIT = 1, 2, 4.
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int m = 0; m < 4; m++) begin
          @(negedge clk);
          s_a = 4'(av); s_b = 4'(bv);
          s_sub = m[1]; s_cin = m[0]; s_start = 1'b1;
          @(posedge clk); #1;
          s_start = 1'b0;
          repeat (4) @(posedge clk);
          #1;
          model(4, longint'(av), longint'(bv), m[1], m[0], ms, mco, mov);
          for (int g = 0; g < 3; g++)
            check($sformatf("sweep_g%0d_a%0d_b%0d_m%0d", g, av, bv, m),
                  {26'd0, s_cout[g], s_ovf[g], s_sum[g]},
                  {26'd0, mco, mov, 4'(ms)});
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
